// File: rtl/rename_map_table_pkg.sv
// Shared widths and types for the integer rename stage: RAT entries, checkpoints
// and a lane-prefix popcount helper used for in-order allocation and push slots.
package rename_map_table_pkg;

  localparam int RENAME_WIDTH       = 4;
  localparam int ARF_INT_INDEX_SIZE = 5;
  localparam int PRF_INT_INDEX_SIZE = 6;
  localparam int RAT_CP_INDEX_SIZE  = 2;

  localparam int NUM_ARF = 1 << ARF_INT_INDEX_SIZE;
  localparam int NUM_PRF = 1 << PRF_INT_INDEX_SIZE;
  localparam int NUM_CP  = 1 << RAT_CP_INDEX_SIZE;
  localparam int CNT_W   = $clog2(RENAME_WIDTH + 1);
  localparam int LANE_W  = $clog2(RENAME_WIDTH);

  typedef logic [ARF_INT_INDEX_SIZE-1:0] arf_t;
  typedef logic [PRF_INT_INDEX_SIZE-1:0] prf_t;

  typedef struct packed {
    logic valid;
    prf_t map;
  } rat_entry_t;

  typedef struct packed {
    rat_entry_t [NUM_ARF-1:0] rat;
    prf_t                     head;
  } checkpoint_t;

  // Number of set bits in v below lane n (n == RENAME_WIDTH gives the full count).
  function automatic logic [CNT_W-1:0] count_below(input logic [RENAME_WIDTH-1:0] v,
                                                   input int n);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      if (j < n && v[j]) c = c + CNT_W'(1);
    end
    return c;
  endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers: up to RENAME_WIDTH pops from head and
// pushes at tail per cycle, with head restore for checkpoint recovery.
module rename_free_list
  import rename_map_table_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CNT_W-1:0]               pop_cnt,
  input  logic [RENAME_WIDTH-1:0]        push,
  input  prf_t [RENAME_WIDTH-1:0]        push_prf,
  input  logic                           restore,
  input  prf_t                           restore_head,
  output prf_t [RENAME_WIDTH-1:0]        peek,
  output prf_t                           head,
  output prf_t                           count
);

  prf_t                    mem [NUM_PRF];
  prf_t                    tail;
  prf_t [RENAME_WIDTH-1:0] wr_idx;
  logic [CNT_W-1:0]        push_cnt;

  // Pointers wrap naturally at NUM_PRF; p0 is never on the list, so count stays <= 63.
  assign count = tail - head;

  always_comb begin
    peek     = '0;
    wr_idx   = '0;
    push_cnt = count_below(push, RENAME_WIDTH);
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      peek[i]   = mem[head + prf_t'(i)];
      wr_idx[i] = tail + prf_t'(count_below(push, i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= prf_t'(NUM_PRF - 1);
      for (int i = 0; i < NUM_PRF; i++) mem[i] <= prf_t'(i + 1);
    end else begin
      head <= restore ? restore_head : head + prf_t'(pop_cnt);
      tail <= tail + prf_t'(push_cnt);
      for (int i = 0; i < RENAME_WIDTH; i++) begin
        if (push[i]) mem[wr_idx[i]] <= push_prf[i];
      end
    end
  end

endmodule

// File: rtl/rename_map_table.sv
// Integer register alias table with intra-group bypass, free-list allocation and
// checkpoint save/restore for branch-mispredict recovery.
module rename_map_table
  import rename_map_table_pkg::*;
(
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic                                              check,
  input  logic [RAT_CP_INDEX_SIZE-1:0]                      check_idx,
  input  logic                                              recover,
  input  logic [RAT_CP_INDEX_SIZE-1:0]                      recover_idx,
  input  logic [RENAME_WIDTH-1:0]                           rd_valid,
  input  logic [RENAME_WIDTH-1:0][ARF_INT_INDEX_SIZE-1:0]   rs1,
  input  logic [RENAME_WIDTH-1:0][ARF_INT_INDEX_SIZE-1:0]   rs2,
  input  logic [RENAME_WIDTH-1:0][ARF_INT_INDEX_SIZE-1:0]   rd,
  input  logic [RENAME_WIDTH-1:0]                           replace_req,
  input  logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   replace_prf,
  output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   prs1,
  output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   prs2,
  output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   prd,
  output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   prev_rd,
  output logic [RENAME_WIDTH-1:0]                           prev_rd_valid,
  output logic                                              allocatable,
  output logic                                              ready
);

  rat_entry_t [NUM_ARF-1:0] rat;
  rat_entry_t [NUM_ARF-1:0] rat_next;
  checkpoint_t              cp [NUM_CP];

  logic [RENAME_WIDTH-1:0]  alloc;
  prf_t [RENAME_WIDTH-1:0]  peek;
  prf_t                     fl_head;
  prf_t                     fl_count;
  logic [CNT_W-1:0]         pop_cnt;
  prf_t                     head_next;
  logic [LANE_W-1:0]        slot;

  assign allocatable = fl_count >= prf_t'(RENAME_WIDTH);
  assign ready       = !reset && !recover;

  rename_free_list u_free_list (
    .clock        (clock),
    .reset        (reset),
    .pop_cnt      (pop_cnt),
    .push         (replace_req),
    .push_prf     (replace_prf),
    .restore      (recover),
    .restore_head (cp[recover_idx].head),
    .peek         (peek),
    .head         (fl_head),
    .count        (fl_count)
  );

  // Lanes take free entries in lane order, skipping lanes that do not allocate.
  always_comb begin
    alloc = '0;
    prd   = '0;
    slot  = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      alloc[i] = rd_valid[i] && (rd[i] != '0) && allocatable;
      slot     = LANE_W'(count_below(alloc, i));
      prd[i]   = alloc[i] ? peek[slot] : '0;
    end
    pop_cnt   = recover ? '0 : count_below(alloc, RENAME_WIDTH);
    head_next = fl_head + prf_t'(pop_cnt);
  end

  // Later lanes in the loop overwrite earlier ones, so the youngest older writer wins.
  always_comb begin
    prs1          = '0;
    prs2          = '0;
    prev_rd       = '0;
    prev_rd_valid = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      prs1[i]          = rat[rs1[i]].map;
      prs2[i]          = rat[rs2[i]].map;
      prev_rd[i]       = rat[rd[i]].map;
      prev_rd_valid[i] = rat[rd[i]].valid;
      for (int j = 0; j < RENAME_WIDTH; j++) begin
        if (j < i && alloc[j]) begin
          if (rd[j] == rs1[i]) prs1[i] = prd[j];
          if (rd[j] == rs2[i]) prs2[i] = prd[j];
          if (rd[j] == rd[i]) begin
            prev_rd[i]       = prd[j];
            prev_rd_valid[i] = 1'b1;
          end
        end
      end
      if (rs1[i] == '0) prs1[i] = '0;
      if (rs2[i] == '0) prs2[i] = '0;
      if (rd[i] == '0) begin
        prev_rd[i]       = '0;
        prev_rd_valid[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rat_next = rat;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      if (alloc[i]) rat_next[rd[i]] = {1'b1, prd[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rat <= '0;
      for (int c = 0; c < NUM_CP; c++) cp[c] <= '0;
    end else if (recover) begin
      rat <= cp[recover_idx].rat;
    end else begin
      rat <= rat_next;
      if (check) cp[check_idx] <= {rat_next, head_next};
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// Scoreboard bench for rename_map_table: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_rename_map_table;
  import rename_map_table_pkg::*;

  logic clock, reset, check, recover, allocatable, ready;
  logic [RAT_CP_INDEX_SIZE-1:0] check_idx, recover_idx;
  logic [RENAME_WIDTH-1:0] rd_valid, replace_req, prev_rd_valid;
  logic [RENAME_WIDTH-1:0][ARF_INT_INDEX_SIZE-1:0] rs1, rs2, rd;
  logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0] replace_prf, prs1, prs2, prd, prev_rd;

  rename_map_table dut (
    .clock(clock), .reset(reset), .check(check), .check_idx(check_idx),
    .recover(recover), .recover_idx(recover_idx), .rd_valid(rd_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .replace_req(replace_req),
    .replace_prf(replace_prf), .prs1(prs1), .prs2(prs2), .prd(prd),
    .prev_rd(prev_rd), .prev_rd_valid(prev_rd_valid),
    .allocatable(allocatable), .ready(ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  localparam int K_PRD = 0, K_PRS1 = 1, K_PRS2 = 2, K_PREV = 3, K_PREVV = 4,
                 K_ALLOC = 5, K_READY = 6;

  typedef struct {
    int cyc;
    int kind;
    int lane;
    int val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic string kname(input int k);
    case (k)
      K_PRD:   return "prd";
      K_PRS1:  return "prs1";
      K_PRS2:  return "prs2";
      K_PREV:  return "prev_rd";
      K_PREVV: return "prev_rd_valid";
      K_ALLOC: return "allocatable";
      default: return "ready";
    endcase
  endfunction

  function automatic int actual(input int k, input int l);
    logic [1:0] ln;
    ln = l[1:0];
    case (k)
      K_PRD:   return int'(prd[ln]);
      K_PRS1:  return int'(prs1[ln]);
      K_PRS2:  return int'(prs2[ln]);
      K_PREV:  return int'(prev_rd[ln]);
      K_PREVV: return int'(prev_rd_valid[ln]);
      K_ALLOC: return int'(allocatable);
      default: return int'(ready);
    endcase
  endfunction

  exp_t e;
  int   a;
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = actual(e.kind, e.lane);
      checks++;
      if (e.cyc != cyc || a != e.val) begin
        failures++;
        $display("FAIL %s lane%0d cyc%0d got=%0d exp=%0d", kname(e.kind), e.lane, e.cyc, a, e.val);
      end
    end
  end

  task automatic expect1(input int k, input int l, input int v);
    sb.push_back('{cyc, k, l, v});
  endtask

  task automatic expect4(input int k, input int v0, input int v1, input int v2, input int v3);
    expect1(k, 0, v0); expect1(k, 1, v1); expect1(k, 2, v2); expect1(k, 3, v3);
  endtask

  function automatic logic [RENAME_WIDTH-1:0][ARF_INT_INDEX_SIZE-1:0] al(
      input int v0, input int v1, input int v2, input int v3);
    logic [RENAME_WIDTH-1:0][ARF_INT_INDEX_SIZE-1:0] r;
    r[0] = arf_t'(v0); r[1] = arf_t'(v1); r[2] = arf_t'(v2); r[3] = arf_t'(v3);
    return r;
  endfunction

  function automatic logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0] pl(
      input int v0, input int v1, input int v2, input int v3);
    logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0] r;
    r[0] = prf_t'(v0); r[1] = prf_t'(v1); r[2] = prf_t'(v2); r[3] = prf_t'(v3);
    return r;
  endfunction

  task automatic clear_inputs();
    reset = 1'b0; check = 1'b0; check_idx = '0; recover = 1'b0; recover_idx = '0;
    rd_valid = '0; rs1 = '0; rs2 = '0; rd = '0; replace_req = '0; replace_prf = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clock); #1;
    expect1(K_READY, 0, 0);

    // Fresh table: allocate x4,x3,x2,x1
    step();
    expect1(K_ALLOC, 0, 1); expect1(K_READY, 0, 1);
    rd_valid = 4'hF; rd = al(4, 3, 2, 1);
    expect4(K_PRD, 1, 2, 3, 4);
    expect4(K_PREVV, 0, 0, 0, 0);
    expect4(K_PREV, 0, 0, 0, 0);

    step();
    rs1 = al(4, 3, 2, 1); rs2 = al(4, 3, 2, 1);
    expect4(K_PRS1, 1, 2, 3, 4);
    expect4(K_PRS2, 1, 2, 3, 4);
    expect4(K_PRD, 0, 0, 0, 0);

    // Intra-group dependency on x5
    step();
    rd_valid = 4'b0011; rd = al(5, 5, 0, 0); rs1 = al(0, 5, 0, 0);
    expect1(K_PRD, 0, 5); expect1(K_PRD, 1, 6);
    expect1(K_PRS1, 1, 5);
    expect1(K_PREV, 1, 5); expect1(K_PREVV, 1, 1);
    expect1(K_PREVV, 0, 0);

    step();
    replace_req = 4'hF; replace_prf = pl(4, 3, 2, 1); rs1 = al(5, 0, 0, 0);
    expect1(K_PRS1, 0, 6);

    // Checkpoint, rename over it, then recover
    step();
    check = 1'b1; check_idx = 2'd1;

    step();
    rd_valid = 4'hF; rd = al(4, 3, 2, 1);
    expect4(K_PRD, 7, 8, 9, 10);
    expect4(K_PREV, 1, 2, 3, 4);
    expect4(K_PREVV, 1, 1, 1, 1);

    step();
    recover = 1'b1; recover_idx = 2'd1;
    rd_valid = 4'hF; rd = al(9, 9, 9, 9); check = 1'b1; check_idx = 2'd1;
    expect1(K_READY, 0, 0);

    step();
    rs1 = al(4, 3, 2, 1); rs2 = al(5, 9, 0, 0);
    rd_valid = 4'b0001; rd = al(7, 0, 0, 0);
    expect4(K_PRS1, 1, 2, 3, 4);
    expect1(K_PRS2, 0, 6); expect1(K_PRS2, 1, 0);
    expect1(K_PRD, 0, 7); expect1(K_READY, 0, 1);

    // Drain: entries p8..p63 in order, then the recycled p4
    for (int k = 0; k < 14; k++) begin
      step();
      rd_valid = 4'hF; rd = al(8, 9, 10, 11);
      expect4(K_PRD, 8 + 4 * k, 9 + 4 * k, 10 + 4 * k, 11 + 4 * k);
      expect1(K_ALLOC, 0, 1);
    end

    step();
    rd_valid = 4'b0001; rd = al(12, 0, 0, 0);
    expect1(K_PRD, 0, 4); expect1(K_ALLOC, 0, 1);

    step();
    rd_valid = 4'hF; rd = al(12, 13, 14, 15);
    expect1(K_ALLOC, 0, 0);
    expect4(K_PRD, 0, 0, 0, 0);
    expect1(K_PREV, 0, 4); expect1(K_PREVV, 0, 1);

    step();
    rs1 = al(12, 13, 8, 0);
    replace_req = 4'b0001; replace_prf = pl(20, 0, 0, 0);
    expect1(K_PRS1, 0, 4); expect1(K_PRS1, 1, 0); expect1(K_PRS1, 2, 60);
    expect1(K_ALLOC, 0, 0);

    // Head has wrapped past slot 63; next entry is the recycled p3
    step();
    rd_valid = 4'b0001; rd = al(13, 0, 0, 0);
    expect1(K_ALLOC, 0, 1); expect1(K_PRD, 0, 3);

    // Reset asserted together with recover
    step();
    reset = 1'b1; recover = 1'b1; recover_idx = 2'd1;
    expect1(K_READY, 0, 0);

    step();
    rd_valid = 4'b0001; rd = al(1, 0, 0, 0); rs1 = al(5, 0, 0, 0);
    expect1(K_ALLOC, 0, 1); expect1(K_PRD, 0, 1);
    expect1(K_PRS1, 0, 0); expect1(K_PREVV, 0, 0);

    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
